// File: rtl/wb_skid_stage_if.sv
// MEM->WB handshake bundle: writeback/commit payload in both directions plus stage status.
// The stage itself takes the slave modport; the memory/writeback side takes master.
interface wb_skid_stage_if #(
  parameter int DATA_W   = 64,
  parameter int RD_W     = 5,
  parameter int OPINFO_W = 12,
  parameter int INSTR_W  = 32,
  parameter int CNT_W    = 64
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [RD_W-1:0]     in_rd;
  logic                in_reg_wen;
  logic [DATA_W-1:0]   in_memdata;
  logic [OPINFO_W-1:0] in_opcode_info;
  logic [DATA_W-1:0]   in_alu_result;
  logic                in_commit;
  logic [DATA_W-1:0]   in_commit_pre_pc;
  logic [INSTR_W-1:0]  in_commit_instr;
  logic [DATA_W-1:0]   in_commit_pc;
  logic                out_valid;
  logic                out_ready;
  logic [RD_W-1:0]     out_rd;
  logic                out_reg_wen;
  logic [DATA_W-1:0]   out_memdata;
  logic [OPINFO_W-1:0] out_opcode_info;
  logic [DATA_W-1:0]   out_alu_result;
  logic                out_commit;
  logic [DATA_W-1:0]   out_commit_pre_pc;
  logic [INSTR_W-1:0]  out_commit_instr;
  logic [DATA_W-1:0]   out_commit_pc;
  logic [1:0]          occupancy;
  logic [CNT_W-1:0]    commit_count;

  modport slave (
    input  flush, in_valid, in_rd, in_reg_wen, in_memdata, in_opcode_info, in_alu_result,
           in_commit, in_commit_pre_pc, in_commit_instr, in_commit_pc, out_ready,
    output in_ready, out_valid, out_rd, out_reg_wen, out_memdata, out_opcode_info,
           out_alu_result, out_commit, out_commit_pre_pc, out_commit_instr, out_commit_pc,
           occupancy, commit_count
  );

  modport master (
    output flush, in_valid, in_rd, in_reg_wen, in_memdata, in_opcode_info, in_alu_result,
           in_commit, in_commit_pre_pc, in_commit_instr, in_commit_pc, out_ready,
    input  in_ready, out_valid, out_rd, out_reg_wen, out_memdata, out_opcode_info,
           out_alu_result, out_commit, out_commit_pre_pc, out_commit_instr, out_commit_pc,
           occupancy, commit_count
  );
endinterface

// File: rtl/wb_skid_stage.sv
// MEM->WB stage with a 2-entry skid buffer: 1-cycle latency, in_ready decoded from state only.
// flush empties the stage next cycle; commit_count tracks retired committing bundles.
module wb_skid_stage #(
  parameter int DATA_W   = 64,
  parameter int RD_W     = 5,
  parameter int OPINFO_W = 12,
  parameter int INSTR_W  = 32,
  parameter int CNT_W    = 64
) (
  input  logic           clk,
  input  logic           rst,
  wb_skid_stage_if.slave bus
);

  typedef struct packed {
    logic [RD_W-1:0]     rd;
    logic                reg_wen;
    logic [DATA_W-1:0]   memdata;
    logic [OPINFO_W-1:0] opcode_info;
    logic [DATA_W-1:0]   alu_result;
    logic                commit;
    logic [DATA_W-1:0]   commit_pre_pc;
    logic [INSTR_W-1:0]  commit_instr;
    logic [DATA_W-1:0]   commit_pc;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  payload_t         main_q, main_d;
  payload_t         skid_q, skid_d;
  payload_t         in_pay;
  logic             in_ready, out_valid;
  logic             in_fire, out_fire;
  logic [CNT_W-1:0] count_q;

  assign in_pay = {bus.in_rd, bus.in_reg_wen, bus.in_memdata, bus.in_opcode_info,
                   bus.in_alu_result, bus.in_commit, bus.in_commit_pre_pc,
                   bus.in_commit_instr, bus.in_commit_pc};

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      // A retirement on the flush cycle still counts; flush only drops held entries.
      if (out_fire && main_q.commit) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Entries are zeroed whenever they go invalid, so an empty main drives a clean bubble.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_pay;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_pay;
        end else if (in_fire) begin
          skid_d  = in_pay;
          state_d = FULL;
        end else if (out_fire) begin
          main_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        main_d  = '0;
        skid_d  = '0;
        state_d = EMPTY;
      end
    endcase
    if (bus.flush) begin
      main_d  = '0;
      skid_d  = '0;
      state_d = EMPTY;
    end
  end

  assign bus.in_ready          = in_ready;
  assign bus.out_valid         = out_valid;
  assign bus.out_rd            = main_q.rd;
  assign bus.out_reg_wen       = main_q.reg_wen;
  assign bus.out_memdata       = main_q.memdata;
  assign bus.out_opcode_info   = main_q.opcode_info;
  assign bus.out_alu_result    = main_q.alu_result;
  assign bus.out_commit        = main_q.commit;
  assign bus.out_commit_pre_pc = main_q.commit_pre_pc;
  assign bus.out_commit_instr  = main_q.commit_instr;
  assign bus.out_commit_pc     = main_q.commit_pc;
  assign bus.occupancy         = state_q;
  assign bus.commit_count      = count_q;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Directed table plus hand-written corner sequences for wb_skid_stage.
module tb_wb_skid_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_skid_stage_if bus ();
  wb_skid_stage_if #(.CNT_W(4)) wbus ();

  wb_skid_stage u_dut (.clk(clk), .rst(rst), .bus(bus));
  wb_skid_stage #(.CNT_W(4)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [63:0] pc;
    logic        cm;
    logic [1:0]  occ;
    logic        ov;
    logic        ir;
    logic [63:0] opc;
    logic [63:0] cnt;
    logic        zero;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [63:0] pc, logic cm,
                              logic [1:0] occ, logic ov, logic ir, logic [63:0] opc,
                              logic [63:0] cnt, logic zero);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.cm = cm;
    v.occ = occ; v.ov = ov; v.ir = ir; v.opc = opc; v.cnt = cnt; v.zero = zero;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic cm);
    bus.in_valid         = v;
    bus.in_rd            = pc[6:2];
    bus.in_reg_wen       = 1'b1;
    bus.in_memdata       = pc ^ 64'hA5A5_5A5A_0F0F_F0F0;
    bus.in_opcode_info   = pc[11:0];
    bus.in_alu_result    = pc + 64'd1;
    bus.in_commit        = cm;
    bus.in_commit_pre_pc = pc - 64'd4;
    bus.in_commit_instr  = pc[31:0] ^ 32'h13;
    bus.in_commit_pc     = pc;
  endtask

  function automatic logic pay_any();
    return |{bus.out_rd, bus.out_reg_wen, bus.out_memdata, bus.out_opcode_info,
             bus.out_alu_result, bus.out_commit, bus.out_commit_pre_pc,
             bus.out_commit_instr, bus.out_commit_pc};
  endfunction

  task automatic check_state(input string tag, input logic [1:0] occ, input logic ov,
                             input logic ir, input logic [63:0] opc, input logic [63:0] cnt);
    check({tag, "_occ"}, 64'(bus.occupancy), 64'(occ));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(ov));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(ir));
    check({tag, "_out_pc"}, bus.out_commit_pc, opc);
    check({tag, "_count"}, bus.commit_count, cnt);
  endtask

  typedef struct {
    logic [63:0] pc;
    logic        cm;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] lfsr;
  logic [63:0] exp_cnt;
  int          sent;
  int          cyc;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    wbus.flush = 1'b0; wbus.in_valid = 1'b0; wbus.out_ready = 1'b0;
    wbus.in_rd = '0; wbus.in_reg_wen = 1'b0; wbus.in_memdata = '0; wbus.in_opcode_info = '0;
    wbus.in_alu_result = '0; wbus.in_commit = 1'b0; wbus.in_commit_pre_pc = '0;
    wbus.in_commit_instr = '0; wbus.in_commit_pc = '0;

    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1, 1, 0, 64'h1000 + 64'(4 * i), 1, 1, 1, 1, 64'h1000 + 64'(4 * i), 64'(i), 0));
    vt.push_back(mk(0, 1, 0, 0,        0, 0, 0, 1, 0,        8,  1));
    vt.push_back(mk(1, 0, 0, 64'h2000, 1, 1, 1, 1, 64'h2000, 8,  0));
    vt.push_back(mk(1, 0, 0, 64'h2004, 1, 2, 1, 0, 64'h2000, 8,  0));
    vt.push_back(mk(0, 1, 0, 0,        0, 1, 1, 1, 64'h2004, 9,  0));
    vt.push_back(mk(0, 1, 0, 0,        0, 0, 0, 1, 0,        10, 1));
    vt.push_back(mk(1, 0, 0, 64'h3000, 1, 1, 1, 1, 64'h3000, 10, 0));
    vt.push_back(mk(1, 0, 0, 64'h3004, 1, 2, 1, 0, 64'h3000, 10, 0));
    vt.push_back(mk(1, 0, 0, 64'h3008, 1, 2, 1, 0, 64'h3000, 10, 0));
    vt.push_back(mk(1, 0, 1, 64'h300C, 1, 0, 0, 1, 0,        10, 1));
    vt.push_back(mk(0, 1, 0, 0,        0, 0, 0, 1, 0,        10, 1));
    vt.push_back(mk(1, 0, 0, 64'h4000, 1, 1, 1, 1, 64'h4000, 10, 0));
    vt.push_back(mk(1, 1, 1, 64'h4004, 1, 0, 0, 1, 0,        11, 1));
    vt.push_back(mk(0, 1, 0, 0,        0, 0, 0, 1, 0,        11, 1));

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 2'd0, 1'b0, 1'b1, 64'd0, 64'd0);
    check("reset_payload", 64'(pay_any()), 64'd0);
    check("reset_wrap_count", 64'(wbus.commit_count), 64'd0);
    rst = 1'b0;

    foreach (vt[k]) begin
      drive(vt[k].iv, vt[k].pc, vt[k].cm);
      bus.out_ready = vt[k].ordy;
      bus.flush     = vt[k].fl;
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", k), vt[k].occ, vt[k].ov, vt[k].ir, vt[k].opc, vt[k].cnt);
      check($sformatf("vec%0d_alu", k), bus.out_alu_result, vt[k].ov ? vt[k].opc + 64'd1 : 64'd0);
      if (vt[k].zero) check($sformatf("vec%0d_payload", k), 64'(pay_any()), 64'd0);
    end
    bus.flush = 1'b0;

    // Alternating commit bits under pseudo-random backpressure, checked against a FIFO model.
    exp_cnt = 64'd11;
    lfsr    = 16'hACE1;
    sent    = 0;
    cyc     = 0;
    while (cyc < 300 && (sent < 20 || sb.size() != 0)) begin
      if (sent < 20) drive(1'b1, 64'h5000 + 64'(4 * sent), (sent % 2) == 0);
      else           drive(1'b0, 64'd0, 1'b0);
      bus.out_ready = lfsr[0];
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rnd_pc", bus.out_commit_pc, e.pc);
          check("rnd_commit", 64'(bus.out_commit), 64'(e.cm));
          if (e.cm) exp_cnt = exp_cnt + 64'd1;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.pc = bus.in_commit_pc;
        e.cm = bus.in_commit;
        sb.push_back(e);
        sent++;
      end
      @(posedge clk);
      #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cyc++;
    end
    drive(1'b0, 64'd0, 1'b0);
    check("rnd_all_sent", 64'(sent), 64'd20);
    check("rnd_drained", 64'(sb.size()), 64'd0);
    check("rnd_count", bus.commit_count, exp_cnt);

    // 4-bit counter wraps after 16 retirements.
    wbus.out_ready = 1'b1;
    wbus.in_commit = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wbus.in_valid     = 1'b1;
      wbus.in_commit_pc = 64'h6000 + 64'(4 * i);
      @(posedge clk);
      #1;
    end
    check("wrap_after_16", 64'(wbus.commit_count), 64'd0);
    wbus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_after_17", 64'(wbus.commit_count), 64'd1);
    check("wrap_empty", 64'(wbus.occupancy), 64'd0);

    // Reset beats flush and handshakes while full.
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h7000, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 64'h7004, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_occ", 64'(bus.occupancy), 64'd2);
    rst = 1'b1;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h7008, 1'b1);
    @(posedge clk); #1;
    check_state("rst_full", 2'd0, 1'b0, 1'b1, 64'd0, 64'd0);
    check("rst_full_payload", 64'(pay_any()), 64'd0);
    rst = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_occ", 64'(bus.occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
